hps_gpi_event_capture: RTL and testbench

Parametrised successor to the fixed 14-input HPS loan-GPI hookup in the interconexion system. It synchronises and debounces NUM_CH FPGA-side inputs and captures enabled rising/falling edges as time-stamped events in a FIFO. The HPS reads the FIFO through an Avalon-MM slave. Each captured event pulses the MPU eventi line to wake cores out of WFE, and also drives a level IRQ.

---
 rtl/hps_gpi_event_capture.sv | 241 ++++++++++++++++++++++++
 tb/tb_hps_gpi_event_capture.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_gpi_event_capture.sv
// hps_gpi_event_capture: synchronises and debounces NUM_CH GPI inputs, captures
// enabled rising/falling edges as events in a FIFO read over Avalon-MM, pulses
// mpu_eventi per captured event and drives a level IRQ.
// Optional macro GPI_EVENT_TIMESTAMP_EN: when defined, a free-running TS_W-bit
// timestamp is stored in entry bits [TS_W-1:0]; otherwise bits [23:0] read 0.
// Ports:
//   clk_clk, reset_reset_n  clock, async active-low reset
//   gpi_in                  asynchronous channel inputs
//   avs_*                   Avalon-MM slave (3-bit word address, 1-cycle read latency)
//   mpu_eventi              event pulse to HPS MPU (WFE wake)
//   irq                     level interrupt: IRQ_EN & FIFO not empty
module hps_gpi_event_capture #(
    parameter int unsigned NUM_CH       = 14,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DBW          = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TS_W         = 16,
    parameter int unsigned EVENTI_PULSE = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [NUM_CH-1:0] gpi_in,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              mpu_eventi,
    output logic              irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = $clog2(EVENTI_PULSE + 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [DBW-1:0]    db_cnt_q [NUM_CH];
    logic [DBW-1:0]    db_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] stable_q, stable_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_rise_q, pend_rise_d;
    logic [NUM_CH-1:0] rise_en_q, rise_en_d;
    logic [NUM_CH-1:0] fall_en_q, fall_en_d;
    logic [DBW-1:0]    limit_q, limit_d;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [EW-1:0]     ev_cnt_q, ev_cnt_d;
    logic              eventi_q, eventi_d;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
`ifdef GPI_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_q, ts_d;
`endif

    logic [NUM_CH-1:0] synced_c, rise_c, fall_c, edge_c, push_mask_c;
    logic              push_vld_c, push_rise_c, push_acc_c, pop_c, flush_c;
    logic              full_c, empty_c, wr_ctrl_c;
    logic [4:0]        push_ch_c;
    logic [23:0]       ts24_c;
    logic [31:0]       entry_c;
    logic              unused_c;

    assign unused_c = ^avs_writedata;

    // Next-state logic for sync, debounce, edge capture, FIFO and register file
    always_comb begin
        sync_d[0]   = gpi_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) sync_d[s] = sync_q[s-1];
        synced_c    = sync_q[SYNC_STAGES-1];
        stable_d    = stable_q;
        rise_c      = '0;
        fall_c      = '0;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        limit_d     = limit_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        ovf_d       = ovf_q;
        push_vld_c  = 1'b0;
        push_rise_c = 1'b0;
        push_ch_c   = '0;
        push_mask_c = '0;
        rdata_d     = rdata_q;
        for (int i = 0; i < int'(NUM_CH); i++) db_cnt_d[i] = '0;

        // Debounce: stable follows synced after limit+1 consecutive mismatching cycles
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (synced_c[i] != stable_q[i]) begin
                if (db_cnt_q[i] == limit_q) begin
                    stable_d[i] = synced_c[i];
                    rise_c[i]   = synced_c[i];
                    fall_c[i]   = ~synced_c[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
        edge_c = en_q ? ((rise_c & rise_en_q) | (fall_c & fall_en_q)) : '0;

        // Lowest-index pending channel wins the single push slot
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (pend_q[i] && !push_vld_c) begin
                push_vld_c     = 1'b1;
                push_rise_c    = pend_rise_q[i];
                push_ch_c      = 5'(i);
                push_mask_c[i] = 1'b1;
            end
        end

`ifdef GPI_EVENT_TIMESTAMP_EN
        ts_d   = ts_q + TS_W'(1);
        ts24_c = 24'(ts_q);
`else
        ts24_c = '0;
`endif
        entry_c = {1'b1, push_rise_c, 1'b0, push_ch_c, ts24_c};

        empty_c    = (count_q == '0);
        full_c     = (count_q == CW'(FIFO_DEPTH));
        wr_ctrl_c  = avs_write && (avs_address == 3'd5);
        flush_c    = wr_ctrl_c && avs_writedata[2];
        pop_c      = avs_read && (avs_address == 3'd1) && !empty_c;
        push_acc_c = push_vld_c && (!full_c || pop_c) && !flush_c;

        // A fresh edge on a still-pending channel loses the older event
        pend_d      = flush_c ? '0 : ((pend_q & ~push_mask_c) | edge_c);
        pend_rise_d = (pend_rise_q & ~edge_c) | (rise_c & edge_c);

        if (wr_ctrl_c && avs_writedata[1]) ovf_d = 1'b0;
        if (|(edge_c & pend_q & ~push_mask_c)) ovf_d = 1'b1;
        if (push_vld_c && full_c && !pop_c && !flush_c) ovf_d = 1'b1;

        wr_ptr_d = push_acc_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_acc_c && !pop_c) count_d = count_q + CW'(1);
        if (!push_acc_c && pop_c) count_d = count_q - CW'(1);
        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        if (avs_write) begin
            case (avs_address)
                3'd2: rise_en_d = avs_writedata[NUM_CH-1:0];
                3'd3: fall_en_d = avs_writedata[NUM_CH-1:0];
                3'd5: begin
                    en_d     = avs_writedata[0];
                    irq_en_d = avs_writedata[3];
                end
                3'd6: limit_d = avs_writedata[DBW-1:0];
                default: ;
            endcase
        end

        if (avs_read) begin
            case (avs_address)
                3'd0: rdata_d = {15'b0, 9'(count_q), 5'b0, ovf_q, full_c, empty_c};
                3'd1: rdata_d = empty_c ? 32'h0 : mem_q[rd_ptr_q];
                3'd2: rdata_d = 32'(rise_en_q);
                3'd3: rdata_d = 32'(fall_en_q);
                3'd4: rdata_d = 32'(stable_q);
                3'd5: rdata_d = {28'b0, irq_en_q, 2'b0, en_q};
                3'd6: rdata_d = 32'(limit_q);
                default: rdata_d = 32'h0;
            endcase
        end

        // Each accepted push restarts the eventi pulse
        if (push_acc_c)            ev_cnt_d = EW'(EVENTI_PULSE);
        else if (ev_cnt_q != '0)   ev_cnt_d = ev_cnt_q - EW'(1);
        else                       ev_cnt_d = '0;
        eventi_d = (ev_cnt_d != '0);
        irq_d    = irq_en_q && !empty_c;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) db_cnt_q[i] <= '0;
            stable_q    <= '0;
            pend_q      <= '0;
            pend_rise_q <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            limit_q     <= '0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_cnt_q    <= '0;
            eventi_q    <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
`ifdef GPI_EVENT_TIMESTAMP_EN
            ts_q        <= '0;
`endif
        end else begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_d[s];
            for (int i = 0; i < int'(NUM_CH); i++) db_cnt_q[i] <= db_cnt_d[i];
            stable_q    <= stable_d;
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            limit_q     <= limit_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ev_cnt_q    <= ev_cnt_d;
            eventi_q    <= eventi_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
`ifdef GPI_EVENT_TIMESTAMP_EN
            ts_q        <= ts_d;
`endif
        end
    end

    // Event storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk_clk) begin
        if (push_acc_c) mem_q[wr_ptr_q] <= entry_c;
    end

    assign avs_readdata = rdata_q;
    assign mpu_eventi   = eventi_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_hps_gpi_event_capture.sv
module tb_hps_gpi_event_capture;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [13:0] gpi_in = '0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        mpu_eventi;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

`ifdef GPI_EVENT_TIMESTAMP_EN
    localparam logic [31:0] TS_MASK = 32'h0000_FFFF;
`else
    localparam logic [31:0] TS_MASK = 32'h0000_0000;
`endif

    hps_gpi_event_capture dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .gpi_in        (gpi_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .mpu_eventi    (mpu_eventi),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        #1;
        n_cmp++;
        if ({avs_readdata, mpu_eventi, irq} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%h ev=%b irq=%b want all 0", avs_readdata, mpu_eventi, irq);
        end
        tick(3);
        reset_reset_n = 1'b1;
        tick(2);
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), d);
            n_cmp++;
            if (d !== exp_tab[a]) begin
                n_err++;
                $display("FAIL reset_read_addr%0d: got %h want %h", a, d, exp_tab[a]);
            end
        end
        bus_rd(3'd0, d);
        tick(3);
        n_cmp++;
        if (avs_readdata !== 32'h1) begin
            n_err++;
            $display("FAIL readdata_hold: got %h want 00000001", avs_readdata);
        end
        bus_wr(3'd3, 32'hFFFF_FFFF);
        bus_rd(3'd3, d);
        n_cmp++;
        if (d !== 32'h0000_3FFF) begin
            n_err++;
            $display("FAIL fall_en_width: got %h want 00003fff", d);
        end
        bus_wr(3'd3, 32'h0);
        bus_wr(3'd0, 32'hFFFF_FFFF);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL status_ro_write: got %h want 00000001", d);
        end
    endtask

    task automatic test_first_event();
        logic [31:0] d;
        int lat;
        int hi;
        bus_wr(3'd6, 32'd3);
        bus_wr(3'd2, 32'h1);
        bus_wr(3'd5, 32'h1);
        gpi_in[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (mpu_eventi === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat !== 7) begin
            n_err++;
            $display("FAIL first_event_latency: got %0d cycles want 7", lat);
        end
        hi = (lat != 0) ? 1 : 0;
        for (int i = 0; i < 20 && hi != 0; i++) begin
            tick(1);
            if (mpu_eventi === 1'b1) hi++;
            else break;
        end
        n_cmp++;
        if (hi !== 4) begin
            n_err++;
            $display("FAIL eventi_pulse_len: got %0d want 4", hi);
        end
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h100) begin
            n_err++;
            $display("FAIL first_event_status: got %h want 00000100", d);
        end
        bus_rd(3'd1, d);
        n_cmp++;
        if ((d & ~TS_MASK) !== 32'hC000_0000) begin
            n_err++;
            $display("FAIL first_event_entry: got %h want c0000000 (ts masked)", d);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_disabled: got %b want 0", irq);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        bus_wr(3'd6, 32'd5);
        bus_wr(3'd2, 32'h5);
        gpi_in[2] = 1'b1;
        tick(3);
        gpi_in[2] = 1'b0;
        tick(15);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL glitch_status: got %h want 00000001", d);
        end
        bus_rd(3'd4, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL glitch_level: got %h want 00000001", d);
        end
        gpi_in[2] = 1'b1;
        tick(20);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h100) begin
            n_err++;
            $display("FAIL held_status: got %h want 00000100", d);
        end
        bus_rd(3'd4, d);
        n_cmp++;
        if (d !== 32'h5) begin
            n_err++;
            $display("FAIL held_level: got %h want 00000005", d);
        end
        bus_rd(3'd1, d);
        n_cmp++;
        if ((d & ~TS_MASK) !== 32'hC200_0000) begin
            n_err++;
            $display("FAIL held_entry: got %h want c2000000 (ts masked)", d);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d;
        bus_wr(3'd6, 32'd0);
        bus_wr(3'd2, 32'hF);
        gpi_in[1] = 1'b1;
        gpi_in[3] = 1'b1;
        tick(10);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h200) begin
            n_err++;
            $display("FAIL pair_status: got %h want 00000200", d);
        end
        bus_rd(3'd1, d1);
        bus_rd(3'd1, d2);
        n_cmp++;
        if ((d1 & ~TS_MASK) !== 32'hC100_0000) begin
            n_err++;
            $display("FAIL pair_first_ch1: got %h want c1000000 (ts masked)", d1);
        end
        n_cmp++;
        if ((d2 & ~TS_MASK) !== 32'hC300_0000) begin
            n_err++;
            $display("FAIL pair_second_ch3: got %h want c3000000 (ts masked)", d2);
        end
`ifdef GPI_EVENT_TIMESTAMP_EN
        n_cmp++;
        if ((d2 & TS_MASK) !== ((d1 + 32'd1) & TS_MASK)) begin
            n_err++;
            $display("FAIL pair_ts_delta: got %h want %h", d2 & TS_MASK, (d1 + 32'd1) & TS_MASK);
        end
`endif
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] exp;
        bus_wr(3'd3, 32'h1);
        bus_wr(3'd2, 32'h1);
        bus_wr(3'd5, 32'h9);
        for (int k = 0; k < 17; k++) begin
            gpi_in[0] = ~gpi_in[0];
            tick(5);
        end
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1006) begin
            n_err++;
            $display("FAIL full_status: got %h want 00001006", d);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_full: got %b want 1", irq);
        end
        bus_wr(3'd5, 32'hB);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1002) begin
            n_err++;
            $display("FAIL ovf_clear_status: got %h want 00001002", d);
        end
        for (int k = 0; k < 16; k++) begin
            bus_rd(3'd1, d);
            exp = (k % 2 == 1) ? 32'hC000_0000 : 32'h8000_0000;
            n_cmp++;
            if ((d & ~TS_MASK) !== exp) begin
                n_err++;
                $display("FAIL drain_entry%0d: got %h want %h (ts masked)", k, d, exp);
            end
        end
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL drained_status: got %h want 00000001", d);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_empty: got %b want 0", irq);
        end
        bus_rd(3'd1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL empty_read: got %h want 00000000", d);
        end
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL empty_read_status: got %h want 00000001", d);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        for (int k = 0; k < 5; k++) begin
            gpi_in[0] = ~gpi_in[0];
            tick(5);
        end
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h500) begin
            n_err++;
            $display("FAIL pre_flush_status: got %h want 00000500", d);
        end
        bus_wr(3'd3, 32'hF);
        bus_wr(3'd2, 32'hF);
        gpi_in[3:1] = 3'b000;
        tick(3);
        bus_wr(3'd5, 32'hD);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL flush_status: got %h want 00000001", d);
        end
        tick(10);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL post_flush_status: got %h want 00000001", d);
        end
        bus_rd(3'd4, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL post_flush_level: got %h want 00000001", d);
        end
        bus_rd(3'd5, d);
        n_cmp++;
        if (d !== 32'h9) begin
            n_err++;
            $display("FAIL ctrl_readback: got %h want 00000009", d);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] d;
        bit seen;
        seen = 1'b0;
        gpi_in[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (mpu_eventi === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL mid_pulse_wait: got no eventi within 20 cycles want eventi=1");
        end
        #2;
        reset_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mpu_eventi, irq} !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset_outputs: got ev=%b irq=%b want 0 0", mpu_eventi, irq);
        end
        tick(2);
        reset_reset_n = 1'b1;
        tick(1);
        bus_rd(3'd0, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL after_reset_status: got %h want 00000001", d);
        end
        bus_rd(3'd5, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL after_reset_ctrl: got %h want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_debounce();
        test_same_cycle();
        test_overflow();
        test_flush();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
